// File: rtl/rtc_port_responder_if.sv
// PicoBlaze port-bus bundle between the micro wrapper (master) and the RTC responder (slave).
interface rtc_port_responder_if;
    logic       sel;
    logic [7:0] dir;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;

    modport master (output sel, dir, write_strobe, read_strobe, data_in,
                    input  data_out, busy);
    modport slave  (input  sel, dir, write_strobe, read_strobe, data_in,
                    output data_out, busy);
endinterface

// File: rtl/rtc_port_responder.sv
// RTC port responder: port-mapped address/write/read registers driving a timed muxed AD bus cycle.
// Define RTC_SYNC_EN to pass ad_in through a 2-flop synchronizer before capture (needs T_PULSE >= 3).
module rtc_port_responder #(
    parameter int T_PULSE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_port_responder_if.slave  pb,
    output logic [7:0]           ad_out,
    output logic                 ad_oe,
    input  logic [7:0]           ad_in,
    output logic                 cs_n,
    output logic                 rd_n,
    output logic                 wr_n,
    output logic                 a_d
);
    localparam int CW = (T_PULSE > 2) ? $clog2(T_PULSE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_DATA, S_RECOVER} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      addr_reg_q, addr_reg_d;
    logic [7:0]      addr_run_q, addr_run_d;
    logic [7:0]      wdata_reg_q, wdata_reg_d;
    logic [7:0]      rdata_reg_q, rdata_reg_d;
    logic            is_wr_q, is_wr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      data_out_q, data_out_d;
    logic [7:0]      cap_data;

    logic wr_hit, start_req, start_ok, stat_rd, phase_last, busy;

    assign busy       = (state_q != S_IDLE);
    assign wr_hit     = pb.sel && pb.write_strobe;
    assign start_req  = wr_hit && (pb.dir == 8'h01 || pb.dir == 8'h02);
    assign start_ok   = start_req && !busy;
    assign stat_rd    = pb.sel && pb.read_strobe && (pb.dir == 8'h00);
    assign phase_last = (cnt_q == CW'(T_PULSE - 1));

`ifdef RTC_SYNC_EN
    logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = ad_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign cap_data = sync2_q;
`else
    assign cap_data = ad_in;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: every non-idle phase lasts exactly T_PULSE cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (state_q != S_IDLE && !phase_last)
            cnt_d = cnt_q + CW'(1);
        unique case (state_q)
            S_IDLE:    if (start_ok)   state_d = S_ADDR;
            S_ADDR:    if (phase_last) state_d = S_GAP;
            S_GAP:     if (phase_last) state_d = S_DATA;
            S_DATA:    if (phase_last) state_d = S_RECOVER;
            S_RECOVER: if (phase_last) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Bus outputs decoded from the current phase
    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        a_d    = 1'b1;
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        unique case (state_q)
            S_ADDR: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                a_d    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_run_q;
            end
            S_GAP: begin
                ad_oe  = 1'b1;
                ad_out = addr_run_q;
            end
            S_DATA: begin
                cs_n = 1'b0;
                if (is_wr_q) begin
                    wr_n   = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = wdata_reg_q;
                end else begin
                    rd_n = 1'b0;
                end
            end
            S_RECOVER: begin
                ad_oe  = is_wr_q;
                ad_out = is_wr_q ? wdata_reg_q : 8'h00;
            end
            default: ;
        endcase
    end

    // Software-visible registers; a rejected start leaves everything but err untouched
    always_comb begin
        addr_reg_d  = addr_reg_q;
        addr_run_d  = addr_run_q;
        wdata_reg_d = wdata_reg_q;
        rdata_reg_d = rdata_reg_q;
        is_wr_d     = is_wr_q;
        done_d      = done_q;
        err_d       = err_q;

        if (wr_hit && pb.dir == 8'h00)
            addr_reg_d = pb.data_in;
        if (start_ok) begin
            addr_run_d = addr_reg_q;
            is_wr_d    = (pb.dir == 8'h01);
            done_d     = 1'b0;
            if (pb.dir == 8'h01)
                wdata_reg_d = pb.data_in;
        end
        if (state_q == S_DATA && phase_last && !is_wr_q)
            rdata_reg_d = cap_data;
        if (state_q == S_RECOVER && phase_last)
            done_d = 1'b1;
        // set has priority over the clear-on-read
        if (start_req && busy)
            err_d = 1'b1;
        else if (stat_rd)
            err_d = 1'b0;
    end

    always_comb begin
        data_out_d = 8'h00;
        if (pb.sel) begin
            unique case (pb.dir)
                8'h00:   data_out_d = {5'b0, err_q, done_q, busy};
                8'h01:   data_out_d = rdata_reg_q;
                default: data_out_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg_q  <= '0;
            addr_run_q  <= '0;
            wdata_reg_q <= '0;
            rdata_reg_q <= '0;
            is_wr_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= '0;
        end else begin
            addr_reg_q  <= addr_reg_d;
            addr_run_q  <= addr_run_d;
            wdata_reg_q <= wdata_reg_d;
            rdata_reg_q <= rdata_reg_d;
            is_wr_q     <= is_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            data_out_q  <= data_out_d;
        end
    end

    assign pb.data_out = data_out_q;
    assign pb.busy     = busy;
endmodule

// File: tb/tb_rtc_port_responder.sv
// Randomized scoreboard bench for rtc_port_responder against a cycle-arithmetic transaction model.
module tb_rtc_port_responder;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_port_responder_if pb();
    logic [7:0] ad_out, ad_in;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d;

    rtc_port_responder #(.T_PULSE(T)) dut (
        .clk(clk), .reset(reset), .pb(pb),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: one transaction record, started by a strobe in cycle s
    bit         have_txn;
    int         s;
    bit         t_wr;
    logic [7:0] t_addr, t_wdata, t_rdata, rdata_old, m_addr;
    bit         m_err;

    logic [7:0] exp_q[$];
    bit         chk_en;

    function automatic int phase(int c);
        if (!have_txn || c <= s || c > s + 4*T) return -1;
        return (c - s - 1) / T;
    endfunction
    function automatic bit busy_at(int c);
        return phase(c) >= 0;
    endfunction
    function automatic bit done_at(int c);
        return have_txn && (c > s + 4*T);
    endfunction
    function automatic logic [7:0] rdata_at(int c);
        return (have_txn && !t_wr && c > s + 3*T) ? t_rdata : rdata_old;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic model_reset();
        have_txn = 0; s = 0; t_wr = 0; m_err = 0;
        t_addr = 0; t_wdata = 0; t_rdata = 0; rdata_old = 0; m_addr = 0;
    endtask

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick(1);
    endtask

    // One port access lasting one cycle; optionally expects data_out for this dir/sel
    task automatic op(bit sl, logic [7:0] d, bit w, bit r, logic [7:0] din, bit want);
        int c;
        logic [7:0] e;
        c = cyc;
        pb.sel = sl; pb.dir = d; pb.write_strobe = w; pb.read_strobe = r; pb.data_in = din;
        if (want && sl) begin
            e = (d == 8'h00) ? {5'b0, m_err, done_at(c), busy_at(c)} :
                (d == 8'h01) ? rdata_at(c) : 8'h00;
            exp_q.push_back(e);
            chk_en = 1;
        end
        if (sl && r && d == 8'h00) m_err = 0;
        if (sl && w) begin
            if (d == 8'h00) m_addr = din;
            else if (d == 8'h01 || d == 8'h02) begin
                if (busy_at(c)) m_err = 1;
                else begin
                    rdata_old = rdata_at(c);
                    have_txn = 1; s = c; t_wr = (d == 8'h01); t_addr = m_addr;
                    if (d == 8'h01) t_wdata = din;
                    t_rdata = 8'($urandom);
                end
            end
        end
        tick(1);
        pb.write_strobe = 0; pb.read_strobe = 0; chk_en = 0;
    endtask

    // RTC chip model: drives the read value through the whole DATA phase, noise otherwise
    always @(posedge clk) begin
        #2;
        if (phase(cyc) == 2 && !t_wr) ad_in = t_rdata;
        else ad_in = 8'($urandom);
    end

    // Data_out scoreboard monitor
    initial begin
        forever begin
            @(posedge clk);
            if (chk_en) begin
                @(negedge clk);
                if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
                else chk("data_out", pb.data_out, exp_q.pop_front());
            end
        end
    end

    // Bus-phase monitor, every cycle
    always @(negedge clk) begin
        int p;
        logic [5:0] e;
        p = phase(cyc);
        e = {p >= 0,
             !(p == 0 || p == 2),
             !(p == 2 && !t_wr),
             !(p == 0 || (p == 2 && t_wr)),
             p != 0,
             (p == 0 || p == 1 || (p >= 2 && t_wr))};
        chk("busy_cs_rd_wr_ad_oe", {pb.busy, cs_n, rd_n, wr_n, a_d, ad_oe}, e);
        if (e[0]) chk("ad_out", ad_out, (p <= 1) ? t_addr : t_wdata);
    end

    initial begin
        int s0, k;
        logic [7:0] d;
        model_reset();
        chk_en = 0;
        reset = 1;
        pb.sel = 0; pb.dir = 0; pb.write_strobe = 0; pb.read_strobe = 0; pb.data_in = 0;
        ad_in = 0;
        tick(3);
        chk("rst_data_out", pb.data_out, 8'h00);
        chk("rst_ad_out", ad_out, 8'h00);
        reset = 0;
        tick(2);

        // idle status
        op(1, 8'h00, 0, 1, 0, 1);
        // write transaction
        op(1, 8'h00, 1, 0, 8'h21, 0);
        op(1, 8'h01, 1, 0, 8'h55, 0);
        tick(4*T + 2);
        op(1, 8'h00, 0, 1, 0, 1);
        op(1, 8'h01, 0, 1, 0, 1);
        // read transaction with chip returning 0xA7
        op(1, 8'h00, 1, 0, 8'h21, 0);
        op(1, 8'h02, 1, 0, 8'hFF, 0);
        t_rdata = 8'hA7;
        tick(4*T + 2);
        op(1, 8'h01, 0, 1, 0, 1);
        op(1, 8'h00, 0, 1, 0, 1);
        // start while busy: err set, seen by peek, cleared by the first status read after
        s0 = cyc;
        op(1, 8'h01, 1, 0, 8'h3C, 0);
        wait_until(s0 + 5);
        op(1, 8'h01, 1, 0, 8'hC3, 0);
        op(1, 8'h00, 0, 0, 0, 1);
        tick(4*T + 2);
        op(1, 8'h00, 0, 1, 0, 1);
        op(1, 8'h00, 0, 1, 0, 1);
        // reset mid-write
        s0 = cyc;
        op(1, 8'h01, 1, 0, 8'h99, 0);
        wait_until(s0 + 10);
        reset = 1;
        model_reset();
        #1;
        chk("midrst_busy", pb.busy, 0);
        chk("midrst_cs_wr", {cs_n, wr_n}, 2'b11);
        chk("midrst_oe", ad_oe, 0);
        tick(2);
        reset = 0;
        op(1, 8'h00, 0, 1, 0, 1);
        // deselected start
        op(0, 8'h01, 1, 0, 8'h77, 0);
        tick(3);
        op(1, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            d = 8'($urandom);
            case (k)
                0: op(1, 8'h00, 1, 0, d, 0);
                1: op(1, 8'h01, 1, 0, d, 0);
                2: op(1, 8'h02, 1, 0, d, 0);
                3: op(1, 8'h00, 0, 1, 0, 1);
                4: op(1, 8'h01, 0, 1, 0, 1);
                5: op(1, 8'($urandom_range(0, 1)), 0, 0, 0, 1);
                6: op(1, 8'($urandom_range(3, 255)), $urandom_range(0, 1), 1'b1, d, 1);
                7: op(0, 8'($urandom_range(0, 2)), 1'b1, $urandom_range(0, 1), d, 0);
                8: tick($urandom_range(0, 6));
                default: tick(4*T + 1);
            endcase
        end
        tick(4*T + 2);
        op(1, 8'h00, 0, 1, 0, 1);
        op(1, 8'h01, 0, 1, 0, 1);
        tick(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_port_responder.md
# rtc_port_responder

Responder on the PicoBlaze port bus for the RTC peripheral: accepts port writes/reads qualified by the RTC chip-select and port address from the micro wrapper, and runs timed transactions on the RTC chip's multiplexed address/data bus. Software latches an RTC register address, then starts a write or read and polls status. The read result returns on a registered data port feeding the micro's RTC input mux.

## Interface
- T_PULSE, 10: cycles per bus phase (address, gap, data, recover); minimum 2, or 3 with RTC_SYNC_EN.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sel  in  1  RTC port select from the address decoder.
- dir  in  8  port address.
- write_strobe  in  1  port write qualifier, one cycle.
- read_strobe  in  1  port read qualifier, one cycle.
- data_in  in  8  PicoBlaze out_port.
- data_out  out  8  registered read data to the micro's RTC input mux.
- busy  out  1  transaction in progress.
- ad_out  out  8  value driven on the RTC AD bus.
- ad_oe  out  1  AD bus output enable.
- ad_in  in  8  AD bus input.
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low.
- a_d  out  1  0 = address phase, 1 = data phase.

## Operation
- Register map, acting only when sel=1:
  - Write dir 0x00: latch addr_reg.
  - Write dir 0x01: latch wdata_reg and start a write transaction.
  - Write dir 0x02: start a read transaction; the written value is ignored.
  - Read dir 0x00: status {5'b0, err, done, busy}.
  - Read dir 0x01: rdata_reg.
  - Any other dir: reads 0x00; writes are ignored.
- FSM states: IDLE, ADDR, GAP, DATA, RECOVER. Each non-IDLE state lasts exactly T_PULSE cycles.
- IDLE outputs: cs_n=rd_n=wr_n=1, a_d=1, ad_oe=0.
- ADDR: cs_n=0, wr_n=0, a_d=0, ad_out=addr_reg, ad_oe=1.
- GAP: strobes high, a_d=1, ad_oe=1, ad_out held.
- DATA, write: cs_n=0, wr_n=0, ad_out=wdata_reg, ad_oe=1.
- DATA, read: cs_n=0, rd_n=0, ad_oe=0. rdata_reg captures ad_in on the last DATA cycle.
- RECOVER: strobes high. ad_oe stays 1 for a write and 0 for a read.
- Status bits:
  - done: cleared when a transaction starts; set on the RECOVER to IDLE transition.
  - err: set when a start arrives while busy (that start is otherwise ignored). Cleared by a status read (read_strobe, sel, dir=0x00). If set and clear occur in the same cycle, set wins.
- Writes to dir 0x00 while busy update addr_reg but do not affect the running transaction, which uses a copy taken at start.
- Reset values: data_out=0x00, busy=0, ad_out=0x00, ad_oe=0, cs_n=rd_n=wr_n=1, a_d=1, all internal registers 0, FSM in IDLE.
- Asserting reset mid-transaction returns everything to the reset values immediately. No partial completion, and done is not set.

## Timing
- A start strobe in cycle 0 puts the FSM in ADDR from cycle 1.
- busy=1 for cycles 1 through 4·T_PULSE. IDLE and done=1 from cycle 4·T_PULSE+1.
- data_out is registered from dir and the internal registers every cycle, giving 1-cycle latency. It is valid within the PicoBlaze 2-cycle INPUT window.
- rdata_reg and done become visible on data_out one cycle after they update.
- A new start is accepted in the first IDLE cycle after RECOVER.

## Configuration
- RTC_SYNC_EN defined: ad_in passes through a 2-flop synchronizer before capture, so rdata_reg takes the value ad_in had 2 cycles before the last DATA cycle. T_PULSE must be at least 3.
- RTC_SYNC_EN undefined: ad_in is captured directly.

## Test plan
All scenarios use T_PULSE=4.
- Reset, then idle: all outputs at reset values; status read returns 0x00.
- Write 0x21 to dir 0x00, then 0x55 to dir 0x01: ADDR cycles 1–4 with ad_out=0x21, a_d=0, wr_n=0. DATA cycles 9–12 with ad_out=0x55, wr_n=0. busy falls at cycle 17; status reads 0x02.
- Write 0x21 to dir 0x00, start a read, with the model driving ad_in=0xA7 during DATA: ad_oe=0 during DATA; data_out for dir 0x01 reads 0xA7; status 0x02.
- Start a write, then issue another start at cycle 5: the second start is ignored and status reads 0x05. After completion, a status read returns 0x06, and the following read returns 0x02.
- Assert reset at cycle 10 of a write: cs_n/wr_n go high, ad_oe and busy go 0 immediately; status after reset reads 0x00.
- sel=0 with write_strobe to dir 0x01: no transaction starts, busy stays 0.
